// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: opcodes, state and control-word encodings and opcode dispatch for mc_ctrl (ORI gated by MC_CTRL_ORI_EN)
package mc_ctrl_pkg;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        IMMWB  = 4'd10,
        JUMP   = 4'd11,
        ORIEX  = 4'd12
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       alusrca;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    // FETCH doubles as the "unsupported opcode" result
    function automatic state_t dispatch(input logic [5:0] op);
        return (op == OP_LW || op == OP_SW) ? MEMADR :
               (op == OP_R)    ? EXEC   :
               (op == OP_BEQ)  ? BRANCH :
               (op == OP_ADDI) ? ADDIEX :
               (op == OP_J)    ? JUMP   :
`ifdef MC_CTRL_ORI_EN
               (op == OP_ORI)  ? ORIEX  :
`endif
               FETCH;
    endfunction
endpackage

// File: rtl/mc_ctrl_sigs.sv
// mc_ctrl_sigs: Moore state-to-control-word map (ORIEX present only with MC_CTRL_ORI_EN)
module mc_ctrl_sigs
    import mc_ctrl_pkg::*;
(
    input  state_t state_i,
    output ctrl_t  ctrl_o
);
    always_comb begin
        ctrl_o         = '0;
        ctrl_o.alusrcb = SRCB_RS2;
        ctrl_o.pcsrc   = PC_ALU;
        ctrl_o.aluop   = ALUOP_ADD;
        unique case (state_i)
            FETCH: begin
                ctrl_o.irwrite = 1'b1;
                ctrl_o.pcwrite = 1'b1;
                ctrl_o.alusrcb = SRCB_FOUR;
            end
            DECODE: ctrl_o.alusrcb = SRCB_IMMSH;
            MEMADR: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
            end
            MEMRD: ctrl_o.iord = 1'b1;
            MEMWB: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.memtoreg = 1'b1;
            end
            MEMWR: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.memwrite = 1'b1;
            end
            EXEC: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl_o.regdst   = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            BRANCH: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_SUB;
                ctrl_o.branch  = 1'b1;
                ctrl_o.pcsrc   = PC_ALUOUT;
            end
            ADDIEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
            end
`ifdef MC_CTRL_ORI_EN
            ORIEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
                ctrl_o.aluop   = ALUOP_OR;
            end
`endif
            IMMWB: ctrl_o.regwrite = 1'b1;
            JUMP: begin
                ctrl_o.pcwrite = 1'b1;
                ctrl_o.pcsrc   = PC_JUMP;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control FSM with memory wait states, illegal-op pulse and retire counter (ORI via MC_CTRL_ORI_EN)
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic             mem_rdy,
    output logic             iord,
    output logic             memwrite,
    output logic             irwrite,
    output logic             pcwrite,
    output logic             branch,
    output logic             alusrca,
    output logic             memtoreg,
    output logic             regdst,
    output logic             regwrite,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [1:0]       aluop,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instret
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q;
    ctrl_t            ctrl;
    logic             retire, fetch_ok;

    mc_ctrl_sigs u_sigs (
        .state_i(state_q),
        .ctrl_o (ctrl)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:  state_d = mem_rdy ? DECODE : FETCH;
            DECODE: state_d = dispatch(op);
            MEMADR: state_d = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  state_d = mem_rdy ? MEMWB : MEMRD;
            MEMWR:  state_d = mem_rdy ? FETCH : MEMWR;
            EXEC:   state_d = ALUWB;
            ADDIEX: state_d = IMMWB;
`ifdef MC_CTRL_ORI_EN
            ORIEX:  state_d = IMMWB;
`endif
            default: state_d = FETCH;
        endcase
    end

    // Only completed instructions count; the DECODE->FETCH illegal path does not
    assign retire = (state_d == FETCH) &&
                    (state_q inside {MEMWB, MEMWR, ALUWB, BRANCH, IMMWB, JUMP});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_q + CNT_W'(retire);
        end
    end

    assign fetch_ok   = (state_q != FETCH) || mem_rdy;
    assign irwrite    = ctrl.irwrite & fetch_ok & ~rst;
    assign pcwrite    = ctrl.pcwrite & fetch_ok & ~rst;
    assign memwrite   = ctrl.memwrite & ~rst;
    assign regwrite   = ctrl.regwrite & ~rst;
    assign branch     = ctrl.branch & ~rst;
    assign iord       = ctrl.iord;
    assign alusrca    = ctrl.alusrca;
    assign memtoreg   = ctrl.memtoreg;
    assign regdst     = ctrl.regdst;
    assign alusrcb    = ctrl.alusrcb;
    assign pcsrc      = ctrl.pcsrc;
    assign aluop      = ctrl.aluop;
    assign state      = state_q;
    assign illegal_op = (state_q == DECODE) && (dispatch(op) == FETCH);
    assign instret    = instret_q;
endmodule
